// File: rtl/diff_alert_pkg.sv
// Shared types and constants for the differential alert sender.
// The FSM encoding is fixed so that 2'b11 is the only illegal code.
package diff_alert_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAlertHi = 2'b01,
        StAlertLo = 2'b10
    } state_e;

    localparam logic AlertPRst = 1'b0;
    localparam logic AlertNRst = 1'b1;

    function automatic int unsigned timer_width(int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/diff_alert_sender_if.sv
// Request/acknowledge and status bundle between the alert sender and its user.
// The master side is the sender itself.
interface diff_alert_sender_if;

    logic alert_req_i;
    logic ack_level_i;
    logic ack_sigint_i;
    logic alert_po;
    logic alert_no;
    logic busy_o;
    logic done_o;
    logic timeout_o;
    logic sigint_o;

    modport master (
        input  alert_req_i,
        input  ack_level_i,
        input  ack_sigint_i,
        output alert_po,
        output alert_no,
        output busy_o,
        output done_o,
        output timeout_o,
        output sigint_o
    );

    modport slave (
        output alert_req_i,
        output ack_level_i,
        output ack_sigint_i,
        input  alert_po,
        input  alert_no,
        input  busy_o,
        input  done_o,
        input  timeout_o,
        input  sigint_o
    );

endinterface

// File: rtl/diff_alert_timer.sv
// Saturating wait-state counter; expired flags the last allowed cycle of a wait state.
module diff_alert_timer
    import diff_alert_pkg::*;
#(
    parameter int unsigned Limit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = timer_width(Limit);
    localparam logic [CntW-1:0] LastVal = CntW'(Limit - 1);
    localparam logic [CntW-1:0] MaxVal  = CntW'(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q >= LastVal);

endmodule

// File: rtl/diff_alert_sender.sv
// Differential alert sender: four-phase handshake on p/n rails against a decoded ack,
// with a one-deep pending request, per-phase timeout and sticky ack integrity flag.
module diff_alert_sender
    import diff_alert_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16
) (
    input logic                        clk_i,
    input logic                        rst_i,
    diff_alert_sender_if.master        bus
);

    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   alert_p_q, alert_n_q;
    logic   busy_q, done_q, done_d;
    logic   timeout_q, timeout_d;
    logic   sigint_q, sigint_d;
    logic   in_wait, timer_clr, timer_expired;

    assign in_wait   = (state_q == StAlertHi) || (state_q == StAlertLo);
    assign timer_clr = (state_d != state_q);

    diff_alert_timer #(
        .Limit (TimeoutCycles)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (timer_clr),
        .en      (in_wait),
        .expired (timer_expired)
    );

    // A valid ack is checked before the timeout so it wins on the last cycle.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        sigint_d  = sigint_q;
        unique case (state_q)
            StIdle: begin
                pending_d = 1'b0;
                if (bus.alert_req_i || pending_q) begin
                    state_d = StAlertHi;
                end
            end
            StAlertHi: begin
                pending_d = pending_q | bus.alert_req_i;
                sigint_d  = sigint_q | bus.ack_sigint_i;
                if (!bus.ack_sigint_i && bus.ack_level_i) begin
                    state_d = StAlertLo;
                end else if (timer_expired) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StAlertLo: begin
                pending_d = pending_q | bus.alert_req_i;
                sigint_d  = sigint_q | bus.ack_sigint_i;
                if (!bus.ack_sigint_i && !bus.ack_level_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (timer_expired) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                pending_d = 1'b0;
            end
        endcase
    end

    // Rails are derived from the next state so they settle on the same edge as the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            alert_p_q <= AlertPRst;
            alert_n_q <= AlertNRst;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            sigint_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            alert_p_q <= (state_d == StAlertHi);
            alert_n_q <= (state_d != StAlertHi);
            busy_q    <= (state_d != StIdle);
            done_q    <= done_d;
            timeout_q <= timeout_d;
            sigint_q  <= sigint_d;
        end
    end

    assign bus.alert_po  = alert_p_q;
    assign bus.alert_no  = alert_n_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.timeout_o = timeout_q;
    assign bus.sigint_o  = sigint_q;

endmodule

// File: tb/tb_diff_alert_sender.sv
// Self-checking bench for diff_alert_sender: fixed vector table, hand sequences for
// pending and integrity corners, then random traffic against a phase-level model.
module tb_diff_alert_sender;

    localparam int unsigned T = 4;
    localparam int NumVecs = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    diff_alert_sender_if bus_if ();

    diff_alert_sender #(
        .TimeoutCycles (T)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = idle, 1 = rails high awaiting ack, 2 = rails low awaiting release.
    int m_phase   = 0;
    int m_elapsed = 0;
    bit m_pend    = 0;
    bit m_sig     = 0;
    bit m_done    = 0;
    bit m_to      = 0;

    int   run_len   = 0;
    logic prev_p    = 1'b0;
    logic prev_busy = 1'b0;

    typedef struct packed {
        logic rst, req, lvl, sig;
        logic p, busy, done, to, sg;
    } vec_t;

    vec_t vecs [NumVecs];

    task automatic expect_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic q, input logic l, input logic s);
        rst                 = r;
        bus_if.alert_req_i  = q;
        bus_if.ack_level_i  = l;
        bus_if.ack_sigint_i = s;
    endtask

    task automatic model_step();
        bit want;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_pend = 0; m_sig = 0; m_done = 0; m_to = 0;
        end else begin
            m_done = 0;
            m_to   = 0;
            if (m_phase == 0) begin
                if (bus_if.alert_req_i || m_pend) begin
                    m_phase   = 1;
                    m_elapsed = 0;
                end
                m_pend = 0;
            end else begin
                want = (m_phase == 1);
                if (bus_if.alert_req_i) m_pend = 1;
                if (bus_if.ack_sigint_i) m_sig = 1;
                if (!bus_if.ack_sigint_i && (bus_if.ack_level_i == want)) begin
                    m_done    = (m_phase == 2);
                    m_phase   = (m_phase == 1) ? 2 : 0;
                    m_elapsed = 0;
                end else if (m_elapsed == int'(T) - 1) begin
                    m_phase   = 0;
                    m_to      = 1;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
        end
    endtask

    task automatic check_model();
        expect_bit("model_p", bus_if.alert_po, m_phase == 1);
        expect_bit("model_n", bus_if.alert_no, m_phase != 1);
        expect_bit("model_busy", bus_if.busy_o, m_phase != 0);
        expect_bit("model_done", bus_if.done_o, m_done);
        expect_bit("model_timeout", bus_if.timeout_o, m_to);
        expect_bit("model_sigint", bus_if.sigint_o, m_sig);
        if (bus_if.busy_o && prev_busy && (bus_if.alert_po == prev_p)) run_len++;
        else run_len = bus_if.busy_o ? 1 : 0;
        expect_bit("dwell_limit", run_len <= int'(T), 1'b1);
        prev_p    = bus_if.alert_po;
        prev_busy = bus_if.busy_o;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        //             rst  req  lvl  sig   p    busy done to   sg
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};

        for (int i = 0; i < NumVecs; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].lvl, vecs[i].sig);
            tick();
            expect_bit($sformatf("vec%0d_p", i), bus_if.alert_po, vecs[i].p);
            expect_bit($sformatf("vec%0d_n", i), bus_if.alert_no, ~vecs[i].p);
            expect_bit($sformatf("vec%0d_busy", i), bus_if.busy_o, vecs[i].busy);
            expect_bit($sformatf("vec%0d_done", i), bus_if.done_o, vecs[i].done);
            expect_bit($sformatf("vec%0d_to", i), bus_if.timeout_o, vecs[i].to);
            expect_bit($sformatf("vec%0d_sig", i), bus_if.sigint_o, vecs[i].sg);
        end

        // Pending request plus a merged third request.
        drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
        expect_bit("pend_enter_hi", bus_if.alert_po, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0); tick();
        expect_bit("pend_lo_p", bus_if.alert_po, 1'b0);
        expect_bit("pend_lo_busy", bus_if.busy_o, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        expect_bit("pend_done", bus_if.done_o, 1'b1);
        expect_bit("pend_gap_p", bus_if.alert_po, 1'b0);
        expect_bit("pend_gap_busy", bus_if.busy_o, 1'b0);
        tick();
        expect_bit("pend_rehi_p", bus_if.alert_po, 1'b1);
        expect_bit("pend_rehi_busy", bus_if.busy_o, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        expect_bit("pend_done2", bus_if.done_o, 1'b1);
        tick();
        expect_bit("no_third_a", bus_if.busy_o, 1'b0);
        tick();
        expect_bit("no_third_b", bus_if.busy_o, 1'b0);

        // Integrity fault holds the state; ack accepted on the last allowed cycle.
        drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_bit($sformatf("sig_hold%0d_p", k), bus_if.alert_po, 1'b1);
            expect_bit($sformatf("sig_hold%0d_sig", k), bus_if.sigint_o, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("sig_accept_p", bus_if.alert_po, 1'b0);
        expect_bit("sig_accept_busy", bus_if.busy_o, 1'b1);
        expect_bit("sig_accept_to", bus_if.timeout_o, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        expect_bit("sig_done", bus_if.done_o, 1'b1);
        expect_bit("sig_sticky", bus_if.sigint_o, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        expect_bit("sig_reset_clr", bus_if.sigint_o, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1); tick(); tick();
        expect_bit("sig_idle_ignored", bus_if.sigint_o, 1'b0);

        // Random traffic, all checks come from the model.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10000; c++) begin
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0) ? ~bus_if.ack_level_i : bus_if.ack_level_i,
                  ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/diff_alert_sender.md
# diff_alert_sender

Differential alert sender that drives a `p`/`n` wire pair toward a remote receiver running `prim_diff_decode`. It performs a four-phase handshake against the decoded acknowledge returned by that receiver, and queues one pending request while busy. It flags acknowledge timeouts and acknowledge signal-integrity faults. It sits directly upstream of the receiver's differential decoder and consumes the decoder outputs of the return path.

## Interface
- `TimeoutCycles`, default 16: cycles allowed in each wait state before abort; legal range ≥ 2.
- `clk_i`, input, 1 bit: clock; single clock domain.
- `rst_i`, input, 1 bit: reset, synchronous and active-high.
- `alert_req_i`, input, 1 bit: request; sampled each cycle and treated as an event when high.
- `ack_level_i`, input, 1 bit: decoded acknowledge level (decoder `level_o`).
- `ack_sigint_i`, input, 1 bit: acknowledge signal-integrity fault (decoder `sigint_o`).
- `alert_po`, output, 1 bit: differential alert, positive rail.
- `alert_no`, output, 1 bit: differential alert, negative rail.
- `busy_o`, output, 1 bit: high while not in Idle.
- `done_o`, output, 1 bit: one-cycle pulse when a handshake completes.
- `timeout_o`, output, 1 bit: one-cycle pulse when a wait state times out.
- `sigint_o`, output, 1 bit: sticky acknowledge integrity error; cleared only by reset.

## Operation
- FSM states:
  - **Idle**: `p`=0, `n`=1.
  - **AlertHi**: `p`=1, `n`=0; wait for `ack_level_i`=1.
  - **AlertLo**: `p`=0, `n`=1; wait for `ack_level_i`=0.
- Transitions:
  - Idle → AlertHi when `alert_req_i` or `pending` is set; `pending` clears on entry.
  - AlertHi → AlertLo on `ack_level_i`=1 with `ack_sigint_i`=0.
  - AlertLo → Idle on `ack_level_i`=0 with `ack_sigint_i`=0; `done_o` pulses on this transition.
  - Any wait state → Idle on timeout; `timeout_o` pulses and `done_o` stays 0.
- While `ack_sigint_i`=1, `ack_level_i` is ignored and the state holds. The timeout counter keeps running during this time.
- `sigint_o` is set on any cycle where `ack_sigint_i`=1 and the state is not Idle. In Idle, `ack_sigint_i` is ignored.
- Pending request:
  - `alert_req_i` high while busy, including on the completing or timeout cycle, sets `pending`.
  - Further requests while `pending` is set are merged; the queue depth is 1.
- Timeout counter:
  - Width is `$clog2(TimeoutCycles+1)`.
  - Clears on every state entry and increments each cycle in AlertHi/AlertLo.
  - Timeout fires when the counter equals `TimeoutCycles-1` and the exit condition is absent. Each wait state therefore lasts at most `TimeoutCycles` cycles.
  - The counter never wraps.
- A valid ack and the timeout in the same cycle: the ack wins.
- Rail invariant: `alert_po` == `~alert_no` in every cycle, including reset.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: state Idle, `alert_po`=0, `alert_no`=1, `busy_o`=0, `done_o`=0, `timeout_o`=0, `sigint_o`=0, `pending`=0, counter 0.
- Reset asserted mid-handshake forces Idle rails on the next edge and drops any pending request.
- Request latency:
  - Request seen in Idle at edge t → `alert_po`=1 and `busy_o`=1 after edge t.
  - Back-to-back requests: after completion, the pending request rises the rails again one cycle later. At least one Idle cycle with `p`=0 always separates handshakes.
- Acknowledge latency:
  - `ack_level_i`=1 sampled at edge k → AlertLo after edge k.
  - `ack_level_i`=0 sampled at edge m → Idle and `done_o`=1 after edge m, for one cycle.
- Minimum handshake is 2 cycles busy when the ack is already present on each phase.

## Structure
- The shared package `diff_alert_pkg` holds:
  - the state enum (2-bit, explicit encodings Idle=2'b00, AlertHi=2'b01, AlertLo=2'b10; 2'b11 is illegal and decodes to Idle next cycle);
  - the rail reset constants `AlertPRst`=0 and `AlertNRst`=1.
- One natural sub-module: `diff_alert_timer`, the parametric saturating wait counter with clear, enable and expired outputs.

## Test plan
- **Reset:** hold `rst_i`=1 for 3 cycles with `alert_req_i`=1 → `p`/`n`=0/1 and all flags 0. One cycle after reset release → `alert_po`=1.
- **Normal handshake:** one request pulse; `ack_level_i`=1 two cycles later, then 0 two cycles after that → state sequence Idle, AlertHi×2, AlertLo×2, Idle. `done_o` pulses once and `timeout_o` stays 0.
- **Timeout:** `TimeoutCycles`=4, request with ack held at 0 → 4 cycles in AlertHi, then Idle with `timeout_o`=1 for one cycle and `done_o`=0.
- **Pending:** a second request during AlertHi → after `done_o`, exactly one Idle cycle, then AlertHi again. A third request merged during the same busy period adds no extra handshake.
- **Integrity:** `ack_sigint_i`=1 for 3 cycles in AlertHi with `ack_level_i`=1 → state held and `sigint_o`=1 sticky. The ack is accepted after `ack_sigint_i` drops. `ack_sigint_i` in Idle leaves `sigint_o`=0.
- **Invariant:** random requests and acks for 10k cycles → `alert_po` != `alert_no` every cycle, and `busy_o` is never high for more than `TimeoutCycles` consecutive cycles in one state.
